alarm_sequencer: RTL and testbench

- Controls the alarm buzzer. Drives the buzzer's `enable` input with a gated on/off beep cadence when the alarm time is reached.
- Handles snooze (limited count), stop, disarm and ring timeout.
- Sits between the time/alarm comparator, the debounced push-buttons and the buzzer.
- Uses the system clock plus the clock's existing 1 Hz tick pulse.

---
 rtl/alarm_sequencer_pkg.sv | 21 ++
 rtl/alarm_sequencer_beep_cadence.sv | 35 +++
 rtl/alarm_sequencer.sv | 143 ++++++++++++++
 tb/tb_alarm_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, default timing
// constants and a small width helper.
package alarm_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    localparam int unsigned DEF_RING_SECS   = 60;
    localparam int unsigned DEF_SNOOZE_SECS = 300;
    localparam int unsigned DEF_MAX_SNOOZE  = 3;
    localparam int unsigned DEF_BEEP_HALF   = 25000000;

    // Larger of two unsigned values, used to size shared counters.
    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_sequencer_beep_cadence.sv
// Beep cadence generator: square wave with BEEP_HALF clk cycles per half period.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   run         high while the alarm is ringing; low reinitialises the cadence
//   phase       current beep half (1 = sounding); 1 whenever run is low
module beep_cadence #(
    parameter int unsigned BEEP_HALF = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic phase
);

    localparam int unsigned BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

    logic [BW-1:0] beep_cnt;

    // Half-period counter; phase toggles on each wrap, restarts high when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_cnt <= '0;
            phase    <= 1'b1;
        end else if (!run) begin
            beep_cnt <= '0;
            phase    <= 1'b1;
        end else if (beep_cnt == BW'(BEEP_HALF - 1)) begin
            beep_cnt <= '0;
            phase    <= ~phase;
        end else begin
            beep_cnt <= beep_cnt + BW'(1);
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: rings the buzzer with a beep cadence when the alarm minute
// begins, with limited snoozes, stop, disarm and ring timeout.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   tick_1hz     one-clk pulse per second
//   alarm_armed  alarm enable switch (level); low forces idle
//   alarm_match  high while current time equals alarm time
//   snooze_btn   debounced one-clk pulse
//   stop_btn     debounced one-clk pulse
//   buzz_en      buzzer enable (ringing and in the sounding beep half)
//   ringing      state is RINGING
//   snoozing     state is SNOOZE
//   snooze_cnt   snoozes used in the current alarm event
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int unsigned RING_SECS   = DEF_RING_SECS,
    parameter int unsigned SNOOZE_SECS = DEF_SNOOZE_SECS,
    parameter int unsigned MAX_SNOOZE  = DEF_MAX_SNOOZE,
    parameter int unsigned BEEP_HALF   = DEF_BEEP_HALF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tick_1hz,
    input  logic                              alarm_armed,
    input  logic                              alarm_match,
    input  logic                              snooze_btn,
    input  logic                              stop_btn,
    output logic                              buzz_en,
    output logic                              ringing,
    output logic                              snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]   snooze_cnt
);

    localparam int unsigned SEC_MAX = umax(RING_SECS, SNOOZE_SECS);
    localparam int unsigned SECW    = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
    localparam int unsigned SNW     = $clog2(MAX_SNOOZE + 1);

    state_t          state_q, state_d;
    logic [SECW-1:0] sec_q, sec_d;
    logic [SNW-1:0]  snz_q, snz_d;
    logic            match_d;
    logic            trig;
    logic            snooze_left;
    logic            ring_timeout;
    logic            snooze_expiry;
    logic            beep_phase;

    // Fire only on the rising edge of match so a stop/disarm inside the
    // matched minute cannot retrigger.
    assign trig          = alarm_match & ~match_d & alarm_armed;
    assign snooze_left   = (snz_q != SNW'(MAX_SNOOZE));
    assign ring_timeout  = tick_1hz & (sec_q == SECW'(RING_SECS - 1));
    assign snooze_expiry = tick_1hz & (sec_q == SECW'(SNOOZE_SECS - 1));

    // State, second counter, snooze counter and match edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sec_q   <= '0;
            snz_q   <= '0;
            match_d <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            snz_q   <= snz_d;
            match_d <= alarm_match;
        end
    end

    // Next-state logic; priority: disarm, stop, snooze, timeout/expiry, trig.
    // Every transition clears sec_cnt, so a coincident tick is consumed.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        snz_d   = snz_q;
        if (!alarm_armed) begin
            state_d = S_IDLE;
            sec_d   = '0;
            snz_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sec_d = '0;
                    if (trig) begin
                        state_d = S_RINGING;
                    end
                end
                S_RINGING: begin
                    if (stop_btn) begin
                        state_d = S_IDLE;
                        sec_d   = '0;
                        snz_d   = '0;
                    end else if ((snooze_btn || ring_timeout) && snooze_left) begin
                        state_d = S_SNOOZE;
                        sec_d   = '0;
                        snz_d   = snz_q + SNW'(1);
                    end else if (ring_timeout) begin
                        state_d = S_IDLE;
                        sec_d   = '0;
                        snz_d   = '0;
                    end else if (tick_1hz) begin
                        sec_d = sec_q + SECW'(1);
                    end
                end
                S_SNOOZE: begin
                    if (stop_btn) begin
                        state_d = S_IDLE;
                        sec_d   = '0;
                        snz_d   = '0;
                    end else if (snooze_expiry) begin
                        state_d = S_RINGING;
                        sec_d   = '0;
                    end else if (tick_1hz) begin
                        sec_d = sec_q + SECW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    sec_d   = '0;
                    snz_d   = '0;
                end
            endcase
        end
    end

    // Cadence restarts high on every RINGING entry since run is low beforehand.
    beep_cadence #(
        .BEEP_HALF (BEEP_HALF)
    ) u_beep (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == S_RINGING),
        .phase (beep_phase)
    );

    // Outputs decoded purely from registers.
    assign buzz_en    = (state_q == S_RINGING) & beep_phase;
    assign ringing    = (state_q == S_RINGING);
    assign snoozing   = (state_q == S_SNOOZE);
    assign snooze_cnt = snz_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed testbench for alarm_sequencer with small timing parameters.
module tb_alarm_sequencer;

    localparam int unsigned RING_SECS   = 4;
    localparam int unsigned SNOOZE_SECS = 3;
    localparam int unsigned MAX_SNOOZE  = 2;
    localparam int unsigned BEEP_HALF   = 4;
    localparam int unsigned TICK_PERIOD = 20;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       alarm_armed;
    logic       alarm_match;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzz_en;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    int checks;
    int errors;

    alarm_sequencer #(
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS),
        .MAX_SNOOZE  (MAX_SNOOZE),
        .BEEP_HALF   (BEEP_HALF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .alarm_armed (alarm_armed),
        .alarm_match (alarm_match),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .buzz_en     (buzz_en),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .snooze_cnt  (snooze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // n seconds: each second is TICK_PERIOD clocks ending with a tick pulse.
    task automatic secs(input int n);
        for (int i = 0; i < n; i++) begin
            steps(TICK_PERIOD - 1);
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
    endtask

    // Produce a fresh rising edge of alarm_match.
    task automatic fire();
        alarm_match = 1'b0;
        step();
        alarm_match = 1'b1;
        step();
    endtask

    task automatic press_stop();
        stop_btn = 1'b1;
        step();
        stop_btn = 1'b0;
    endtask

    task automatic press_snooze();
        snooze_btn = 1'b1;
        step();
        snooze_btn = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic b, input logic r,
                              input logic s, input logic [1:0] c);
        check({tag, ".buzz"}, 32'(buzz_en), 32'(b));
        check({tag, ".ring"}, 32'(ringing), 32'(r));
        check({tag, ".snz"}, 32'(snoozing), 32'(s));
        check({tag, ".cnt"}, 32'(snooze_cnt), 32'(c));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        tick_1hz    = 1'b0;
        alarm_armed = 1'b1;
        alarm_match = 1'b0;
        snooze_btn  = 1'b0;
        stop_btn    = 1'b0;

        // Reset state
        steps(2);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        rst_n = 1'b1;
        steps(2);
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 2'd0);

        // Rising match starts ringing; cadence 4 high / 4 low
        alarm_match = 1'b1;
        step();
        check("trig.ring", 32'(ringing), 32'd1);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("cadence%0d", k), 32'(buzz_en), 32'(((k / 4) % 2) == 0));
            step();
        end
        press_stop();
        check_outs("stop", 1'b0, 1'b0, 1'b0, 2'd0);
        steps(10);
        check("no_retrig", 32'(ringing), 32'd0);

        // Manual snoozes up to the limit
        fire();
        check("ring2", 32'(ringing), 32'd1);
        press_snooze();
        check_outs("snz1", 1'b0, 1'b0, 1'b1, 2'd1);
        secs(2);
        check("snz1_hold", 32'(snoozing), 32'd1);
        secs(1);
        check_outs("snz1_exp", 1'b1, 1'b1, 1'b0, 2'd1);
        press_snooze();
        check_outs("snz2", 1'b0, 1'b0, 1'b1, 2'd2);
        secs(3);
        check_outs("snz2_exp", 1'b1, 1'b1, 1'b0, 2'd2);
        press_snooze();
        check_outs("snz3_ign", 1'b1, 1'b1, 1'b0, 2'd2);
        press_stop();
        check_outs("stop2", 1'b0, 1'b0, 1'b0, 2'd0);

        // Auto-snooze on timeout, then give up after the limit
        fire();
        secs(3);
        check("ring_hold", 32'(ringing), 32'd1);
        secs(1);
        check_outs("auto1", 1'b0, 1'b0, 1'b1, 2'd1);
        secs(3);
        check("auto1_exp", 32'(ringing), 32'd1);
        secs(4);
        check_outs("auto2", 1'b0, 1'b0, 1'b1, 2'd2);
        secs(3);
        check("auto2_exp", 32'(ringing), 32'd1);
        secs(3);
        check("auto3_hold", 32'(ringing), 32'd1);
        secs(1);
        check_outs("auto_end", 1'b0, 1'b0, 1'b0, 2'd0);
        steps(5);
        check("auto_no_retrig", 32'(ringing), 32'd0);

        // Stop and snooze together: stop wins
        fire();
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        step();
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        check_outs("stop_snz", 1'b0, 1'b0, 1'b0, 2'd0);

        // Disarm with snooze while snoozing: disarm wins
        fire();
        press_snooze();
        check("pre_disarm", 32'(snoozing), 32'd1);
        alarm_armed = 1'b0;
        snooze_btn  = 1'b1;
        step();
        snooze_btn  = 1'b0;
        check_outs("disarm", 1'b0, 1'b0, 1'b0, 2'd0);
        alarm_armed = 1'b1;
        steps(3);
        check("rearm_no_trig", 32'(ringing), 32'd0);

        // Timeout tick coincident with snooze: exactly one snooze
        fire();
        secs(3);
        steps(TICK_PERIOD - 1);
        tick_1hz   = 1'b1;
        snooze_btn = 1'b1;
        step();
        tick_1hz   = 1'b0;
        snooze_btn = 1'b0;
        check_outs("tick_snz", 1'b0, 1'b0, 1'b1, 2'd1);
        press_stop();

        // Asynchronous reset mid-ring
        fire();
        check("pre_rst", 32'(buzz_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 2'd0);
        alarm_match = 1'b0;
        steps(2);
        rst_n = 1'b1;
        steps(3);
        check_outs("rst_release", 1'b0, 1'b0, 1'b0, 2'd0);

        // Match already high at reset release rings
        rst_n       = 1'b0;
        alarm_match = 1'b1;
        steps(2);
        rst_n = 1'b1;
        step();
        check("pwrup_ring", 32'(ringing), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
